// File: rtl/exec_unit_if.sv
// Request/write-back bundle between the register-read stage and exec_unit.
interface exec_unit_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic [4:0]   dst_in;
   logic         wb_valid;
   logic [4:0]   wb_dst;
   logic [W-1:0] wb_data;
   logic         busy;

   // Issuing side: register-read stage (or a testbench driver).
   modport master (
      output in_valid, op, src1, src2, dst_in,
      input  in_ready, wb_valid, wb_dst, wb_data, busy
   );

   // Executing side: the unit itself.
   modport slave (
      input  in_valid, op, src1, src2, dst_in,
      output in_ready, wb_valid, wb_dst, wb_data, busy
   );
endinterface

// File: rtl/exec_unit.sv
// Integer execute unit: single-cycle ALU ops plus a 32-iteration shift-add MUL.
// Results go straight to the register file as one-cycle write pulses.
module exec_unit #(
   parameter int unsigned W = 32
) (
   input logic       clk,
   input logic       reset,
   exec_unit_if.slave bus
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpSlt = 3'b100;
   localparam logic [2:0] OpSll = 3'b101;
   localparam logic [2:0] OpMul = 3'b110;
   localparam logic [2:0] OpRsv = 3'b111;

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e       state_q, state_d;
   logic [4:0]   cnt_q;
   logic [W-1:0] mcand_q;
   logic [W-1:0] mplier_q;
   logic [W-1:0] acc_q;
   logic [4:0]   dst_q;
   logic         wb_valid_q;
   logic [4:0]   wb_dst_q;
   logic [W-1:0] wb_data_q;

   logic         accept;
   logic         mul_last;
   logic [W-1:0] alu_res;
   logic [W-1:0] mul_sum;

   assign accept   = bus.in_valid && bus.in_ready;
   assign mul_last = (state_q == StMul) && (cnt_q == 5'd31);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: MUL occupies the unit until the 32nd iteration completes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept && (bus.op == OpMul)) state_d = StMul;
         StMul:  if (cnt_q == 5'd31) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; in_ready drops combinationally with reset so coincident requests are dropped.
   always_comb begin
      bus.in_ready = (state_q == StIdle) && !reset;
      bus.busy     = (state_q == StMul);
   end

   // Single-cycle ALU result from the operands presented at acceptance.
   always_comb begin
      alu_res = '0;
      unique case (bus.op)
         OpAdd: alu_res = bus.src1 + bus.src2;
         OpSub: alu_res = bus.src1 - bus.src2;
         OpAnd: alu_res = bus.src1 & bus.src2;
         OpOr:  alu_res = bus.src1 | bus.src2;
         OpSlt: alu_res = {{(W-1){1'b0}}, ($signed(bus.src1) < $signed(bus.src2))};
         OpSll: alu_res = bus.src1 << bus.src2[4:0];
         OpMul: alu_res = '0;
         OpRsv: alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   // Partial product for the current multiplier bit (LSB of the shifting multiplier).
   always_comb begin
      mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Datapath and write-back registers; a zero destination suppresses the write entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         dst_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_dst_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         if (accept) begin
            if (bus.op == OpMul) begin
               mcand_q  <= bus.src1;
               mplier_q <= bus.src2;
               acc_q    <= '0;
               cnt_q    <= '0;
               dst_q    <= bus.dst_in;
            end else if (bus.dst_in != 5'd0) begin
               wb_valid_q <= 1'b1;
               wb_dst_q   <= bus.dst_in;
               wb_data_q  <= alu_res;
            end
         end else if (state_q == StMul) begin
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (mul_last && (dst_q != 5'd0)) begin
               wb_valid_q <= 1'b1;
               wb_dst_q   <= dst_q;
               wb_data_q  <= mul_sum;
            end
         end
      end
   end

   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_dst   = wb_dst_q;
   assign bus.wb_data  = wb_data_q;

endmodule
